// File: rtl/seq_divider_16by8_if.sv
// ============================================================================
//  Module      : seq_divider_16by8_if
//  Description : Start/busy/done handshake and operand/result bundle for the
//                16-by-8 sequential unsigned divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seq_divider_16by8_if;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   // Controller side: issues operations and consumes results.
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   // Divider side.
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

`default_nettype wire

// File: rtl/seq_divider_16by8.sv
// ============================================================================
//  Module      : seq_divider_16by8
//  Description : Restoring unsigned divider, 16-bit dividend by 8-bit divisor,
//                one quotient bit per clock (17-cycle latency). Divide by zero
//                short-circuits to a one-cycle result flagged by div_by_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_divider_16by8 (
   input logic                 clk,
   input logic                 rst_n,
   seq_divider_16by8_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_LAST_ITER = 4'd15;

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_divisor;
   logic [15:0] r_sr;
   logic [8:0]  r_pr;
   logic [3:0]  r_cnt;
   logic [15:0] r_quotient;
   logic [7:0]  r_remainder;
   logic        r_dbz;
   logic        r_busy;
   logic        r_done;

   logic        w_accept;
   logic        w_div_zero;
   logic        w_last;
   logic [8:0]  w_pr_shift;
   logic        w_q_bit;
   logic [8:0]  w_pr_next;
   logic [15:0] w_sr_next;

   // A new request is taken whenever the divider is not iterating.
   assign w_accept   = bus.start && (r_state != S_RUN);
   assign w_div_zero = (bus.divisor == 8'd0);
   assign w_last     = (r_cnt == c_LAST_ITER);

   // One restoring step: bring in the next dividend bit, trial-subtract.
   assign w_pr_shift = {r_pr[7:0], r_sr[15]};
   assign w_q_bit    = (w_pr_shift >= {1'b0, r_divisor});
   assign w_pr_next  = w_q_bit ? (w_pr_shift - {1'b0, r_divisor}) : w_pr_shift;
   assign w_sr_next  = {r_sr[14:0], w_q_bit};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; DONE accepts a start exactly like IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_state_next = w_div_zero ? S_DONE : S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Handshake flags registered from the next state so outputs come from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next == S_RUN);
         r_done <= (w_state_next == S_DONE);
      end
   end

   // Iteration datapath: operand capture on accept, one shift/subtract per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divisor <= 8'd0;
         r_sr      <= 16'd0;
         r_pr      <= 9'd0;
         r_cnt     <= 4'd0;
      end else if (r_state == S_RUN) begin
         r_sr  <= w_sr_next;
         r_pr  <= w_pr_next;
         r_cnt <= r_cnt + 4'd1;
      end else if (w_accept && !w_div_zero) begin
         r_divisor <= bus.divisor;
         r_sr      <= bus.dividend;
         r_pr      <= 9'd0;
         r_cnt     <= 4'd0;
      end
   end

   // Result registers change only on entry to DONE and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quotient  <= 16'd0;
         r_remainder <= 8'd0;
         r_dbz       <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_quotient  <= w_sr_next;
         r_remainder <= w_pr_next[7:0];
         r_dbz       <= 1'b0;
      end else if (w_accept && w_div_zero) begin
         r_quotient  <= 16'hFFFF;
         r_remainder <= bus.dividend[7:0];
         r_dbz       <= 1'b1;
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_16by8.sv
// ============================================================================
//  Module      : tb_seq_divider_16by8
//  Description : Directed self-checking bench for seq_divider_16by8.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_divider_16by8;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   seq_divider_16by8_if dut_if ();

   seq_divider_16by8 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if.slave)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a one-cycle start; returns in cycle 1 of the operation.
   task automatic issue(input logic [15:0] a, input logic [7:0] b);
      dut_if.start    = 1'b1;
      dut_if.dividend = a;
      dut_if.divisor  = b;
      step();
      dut_if.start    = 1'b0;
   endtask

   // Wait (bounded) for done, then check latency, busy count and results.
   task automatic wait_check(input string tag, input logic [15:0] eq, input logic [7:0] er,
                             input logic edbz, input int exp_lat, input int lat0,
                             input int exp_busy);
      int lat;
      int bc;
      lat = lat0;
      bc  = 0;
      while (dut_if.done !== 1'b1 && lat < 60) begin
         if (dut_if.busy === 1'b1) bc++;
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bc, exp_busy);
      check({tag, "_quotient"}, dut_if.quotient, eq);
      check({tag, "_remainder"}, dut_if.remainder, er);
      check({tag, "_dbz"}, dut_if.div_by_zero, edbz);
      check({tag, "_busy_at_done"}, dut_if.busy, 1'b0);
   endtask

   task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edbz);
      issue(a, b);
      if (edbz) wait_check(tag, eq, er, edbz, 1, 1, 0);
      else      wait_check(tag, eq, er, edbz, 17, 1, 16);
   endtask

   // Directed sequence.
   initial begin
      logic [15:0] ra;
      logic [7:0]  rb;
      int          seen_done;
      tests = 0;
      fails = 0;
      dut_if.start    = 1'b0;
      dut_if.dividend = 16'd0;
      dut_if.divisor  = 8'd0;
      rst_n = 1'b0;
      #1;
      check("rst_busy", dut_if.busy, 1'b0);
      check("rst_done", dut_if.done, 1'b0);
      check("rst_dbz", dut_if.div_by_zero, 1'b0);
      check("rst_quotient", dut_if.quotient, 16'h0000);
      check("rst_remainder", dut_if.remainder, 8'h00);
      step();
      rst_n = 1'b1;
      step();

      // Basic: 1000 / 7 = 142 r 6, then done must drop and results hold.
      run_div("basic", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      step();
      check("basic_done_pulse", dut_if.done, 1'b0);
      check("basic_hold_q", dut_if.quotient, 16'd142);
      step();

      // Maximum operands.
      run_div("max_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
      step();
      run_div("max_01", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
      step();

      // Small and boundary cases.
      run_div("small", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
      step();
      run_div("zero_dividend", 16'h0000, 8'h80, 16'd0, 8'd0, 1'b0);
      step();

      // Divide by zero, then a normal op clears the flag only at its done.
      run_div("dbz", 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
      step();
      check("dbz_done_pulse", dut_if.done, 1'b0);
      issue(16'd20, 8'd3);
      check("dbz_flag_held", dut_if.div_by_zero, 1'b1);
      wait_check("after_dbz", 16'd6, 8'd2, 1'b0, 17, 1, 16);
      step();

      // Start re-asserted in cycles 3..10 with other operands is ignored.
      issue(16'd1000, 8'd7);
      step();
      step();
      dut_if.start    = 1'b1;
      dut_if.dividend = 16'd50;
      dut_if.divisor  = 8'd3;
      repeat (8) step();
      dut_if.start    = 1'b0;
      wait_check("ignore", 16'd142, 8'd6, 1'b0, 17, 11, 6);

      // Back-to-back: start held in the done cycle.
      issue(16'd300, 8'd17);
      check("b2b_busy_next", dut_if.busy, 1'b1);
      wait_check("b2b", 16'd17, 8'd11, 1'b0, 17, 1, 16);

      // Random operands against a bench-side division model, issued back to back.
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 8'($urandom_range(1, 255));
         run_div("rand", ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
         check("rand_invariant",
               32'(dut_if.quotient) * 32'(rb) + 32'(dut_if.remainder), 32'(ra));
      end
      step();

      // Reset in cycle 8 of an operation: outputs clear at once, no done.
      issue(16'd1000, 8'd7);
      repeat (7) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", dut_if.busy, 1'b0);
      check("mid_rst_done", dut_if.done, 1'b0);
      check("mid_rst_quotient", dut_if.quotient, 16'h0000);
      check("mid_rst_remainder", dut_if.remainder, 8'h00);
      check("mid_rst_dbz", dut_if.div_by_zero, 1'b0);
      step();
      rst_n = 1'b1;
      seen_done = 0;
      repeat (20) begin
         step();
         if (dut_if.done === 1'b1) seen_done++;
      end
      check("mid_rst_no_done", seen_done, 0);
      run_div("post_rst", 16'd20, 8'd3, 16'd6, 8'd2, 1'b0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
